// File: rtl/ps2_kbd_ctrl_pkg.sv
// Shared register map, bit positions, receiver state encoding and parity helper
// for the PS/2 keyboard controller.
package ps2_kbd_ctrl_pkg;

    localparam logic [2:0] PS2_RXDATA = 3'd0;
    localparam logic [2:0] PS2_STATUS = 3'd1;
    localparam logic [2:0] PS2_CTRL   = 3'd2;

    localparam int ST_EMPTY  = 0;
    localparam int ST_FULL   = 1;
    localparam int ST_PERR   = 2;
    localparam int ST_FERR   = 3;
    localparam int ST_TOERR  = 4;
    localparam int ST_OVF    = 5;

    localparam int CT_IRQ_EN = 0;
    localparam int CT_RX_EN  = 1;
    localparam int CT_FLUSH  = 2;

    typedef enum logic [1:0] {
        RX_IDLE   = 2'd0,
        RX_DATA   = 2'd1,
        RX_PARITY = 2'd2,
        RX_STOP   = 2'd3
    } rx_state_e;

    // PS/2 uses odd parity over the eight data bits plus the parity bit.
    function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
        return ^{data, par};
    endfunction

endpackage

// File: rtl/ps2_rx_frame.sv
// PS/2 device-to-host frame receiver: pad synchronisers, kclk glitch filter,
// frame FSM with inter-edge timeout; emits one-cycle byte/error pulses.
module ps2_rx_frame
    import ps2_kbd_ctrl_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 8,
    parameter int TIMEOUT_CYC = 5000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    input  logic       kclk,
    input  logic       kdata,
    output logic [7:0] rx_byte,
    output logic       byte_valid,
    output logic       perr,
    output logic       ferr,
    output logic       toerr
);

    localparam int FCW = $clog2(FILTER_LEN + 1);
    localparam int TW  = $clog2(TIMEOUT_CYC + 1);

    logic [SYNC_STAGES-1:0] kclk_sync_r, kdata_sync_r;
    logic [FCW-1:0]         flt_cnt_r;
    logic                   kclk_filt_r, kclk_prev_r;
    logic                   kclk_s, kdata_s, fall_s;

    rx_state_e   state_r, state_nxt_s;
    logic [2:0]  bit_cnt_r, bit_cnt_nxt_s;
    logic [7:0]  shift_r, shift_nxt_s;
    logic        par_r, par_nxt_s;
    logic [TW-1:0] to_cnt_r, to_cnt_nxt_s;
    logic        push_nxt_s, perr_nxt_s, ferr_nxt_s, toerr_nxt_s;
    logic [7:0]  byte_r;
    logic        byte_valid_r, perr_r, ferr_r, toerr_r;

    assign kclk_s  = kclk_sync_r[SYNC_STAGES-1];
    assign kdata_s = kdata_sync_r[SYNC_STAGES-1];
    assign fall_s  = kclk_prev_r & ~kclk_filt_r;

    // Synchronise pads and debounce kclk: the filtered level only moves after FILTER_LEN equal samples.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            kclk_sync_r  <= {SYNC_STAGES{1'b1}};
            kdata_sync_r <= {SYNC_STAGES{1'b1}};
            flt_cnt_r    <= {FCW{1'b0}};
            kclk_filt_r  <= 1'b1;
            kclk_prev_r  <= 1'b1;
        end else begin
            kclk_sync_r  <= {kclk_sync_r[SYNC_STAGES-2:0], kclk};
            kdata_sync_r <= {kdata_sync_r[SYNC_STAGES-2:0], kdata};
            kclk_prev_r  <= kclk_filt_r;
            if (kclk_s == kclk_filt_r) begin
                flt_cnt_r <= {FCW{1'b0}};
            end else if (flt_cnt_r == FCW'(FILTER_LEN - 1)) begin
                flt_cnt_r   <= {FCW{1'b0}};
                kclk_filt_r <= kclk_s;
            end else begin
                flt_cnt_r <= flt_cnt_r + FCW'(1);
            end
        end
    end

    // Frame FSM next state: advance on filtered falling edges, abort on enable loss or timeout.
    always_comb begin
        state_nxt_s   = state_r;
        bit_cnt_nxt_s = bit_cnt_r;
        shift_nxt_s   = shift_r;
        par_nxt_s     = par_r;
        to_cnt_nxt_s  = to_cnt_r;
        push_nxt_s    = 1'b0;
        perr_nxt_s    = 1'b0;
        ferr_nxt_s    = 1'b0;
        toerr_nxt_s   = 1'b0;
        if (!enable) begin
            state_nxt_s  = RX_IDLE;
            to_cnt_nxt_s = {TW{1'b0}};
        end else if (fall_s) begin
            to_cnt_nxt_s = {TW{1'b0}};
            case (state_r)
                RX_IDLE: begin
                    if (!kdata_s) begin
                        state_nxt_s   = RX_DATA;
                        bit_cnt_nxt_s = 3'd0;
                    end else begin
                        state_nxt_s = RX_IDLE;
                    end
                end
                RX_DATA: begin
                    shift_nxt_s = {kdata_s, shift_r[7:1]};
                    if (bit_cnt_r == 3'd7) begin
                        state_nxt_s = RX_PARITY;
                    end else begin
                        bit_cnt_nxt_s = bit_cnt_r + 3'd1;
                    end
                end
                RX_PARITY: begin
                    par_nxt_s   = kdata_s;
                    state_nxt_s = RX_STOP;
                end
                RX_STOP: begin
                    state_nxt_s = RX_IDLE;
                    perr_nxt_s  = ~odd_parity_ok(shift_r, par_r);
                    ferr_nxt_s  = ~kdata_s;
                    push_nxt_s  = odd_parity_ok(shift_r, par_r) & kdata_s;
                end
                default: begin
                    state_nxt_s = RX_IDLE;
                end
            endcase
        end else if (state_r != RX_IDLE) begin
            if (to_cnt_r == TW'(TIMEOUT_CYC - 1)) begin
                state_nxt_s  = RX_IDLE;
                to_cnt_nxt_s = {TW{1'b0}};
                toerr_nxt_s  = 1'b1;
            end else begin
                to_cnt_nxt_s = to_cnt_r + TW'(1);
            end
        end else begin
            to_cnt_nxt_s = {TW{1'b0}};
        end
    end

    // FSM state and registered result pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= RX_IDLE;
            bit_cnt_r    <= 3'd0;
            shift_r      <= 8'h00;
            par_r        <= 1'b0;
            to_cnt_r     <= {TW{1'b0}};
            byte_r       <= 8'h00;
            byte_valid_r <= 1'b0;
            perr_r       <= 1'b0;
            ferr_r       <= 1'b0;
            toerr_r      <= 1'b0;
        end else begin
            state_r      <= state_nxt_s;
            bit_cnt_r    <= bit_cnt_nxt_s;
            shift_r      <= shift_nxt_s;
            par_r        <= par_nxt_s;
            to_cnt_r     <= to_cnt_nxt_s;
            byte_valid_r <= push_nxt_s;
            perr_r       <= perr_nxt_s;
            ferr_r       <= ferr_nxt_s;
            toerr_r      <= toerr_nxt_s;
            if (push_nxt_s) begin
                byte_r <= shift_r;
            end
        end
    end

    assign rx_byte    = byte_r;
    assign byte_valid = byte_valid_r;
    assign perr       = perr_r;
    assign ferr       = ferr_r;
    assign toerr      = toerr_r;

endmodule

// File: rtl/ps2_kbd_ctrl.sv
// MMIO PS/2 keyboard controller: receiver, byte FIFO, RXDATA/STATUS/CTRL
// registers and a level- or pulse-mode interrupt.
module ps2_kbd_ctrl
    import ps2_kbd_ctrl_pkg::*;
#(
    parameter int FIFO_DEPTH  = 16,
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 8,
    parameter int TIMEOUT_CYC = 5000,
    parameter int IRQ_MODE    = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [2:0]  a,
    input  logic [31:0] d,
    input  logic        we,
    output logic [31:0] spo,
    output logic        irq,
    input  logic        kclk,
    input  logic        kdata
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    logic [7:0]    rx_byte_s;
    logic          rx_valid_s, rx_perr_s, rx_ferr_s, rx_toerr_s;
    logic [7:0]    mem_r [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_r, rd_ptr_r;
    logic [CW-1:0] count_r;
    logic          perr_r, ferr_r, toerr_r, ovf_r, irq_en_r, rx_en_r, irq_r;
    logic          empty_s, full_s, wr_rx_s, wr_st_s, wr_ct_s;
    logic          pop_s, push_s, flush_s, ovf_set_s;
    logic [7:0]    head_s;
    logic          unused_d_s;

    ps2_rx_frame #(
        .SYNC_STAGES (SYNC_STAGES),
        .FILTER_LEN  (FILTER_LEN),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_rx (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (rx_en_r),
        .kclk       (kclk),
        .kdata      (kdata),
        .rx_byte    (rx_byte_s),
        .byte_valid (rx_valid_s),
        .perr       (rx_perr_s),
        .ferr       (rx_ferr_s),
        .toerr      (rx_toerr_s)
    );

    assign unused_d_s = ^d[31:6];
    assign empty_s    = (count_r == CW'(0));
    assign full_s     = (count_r == CW'(FIFO_DEPTH));
    assign wr_rx_s    = we & (a == PS2_RXDATA);
    assign wr_st_s    = we & (a == PS2_STATUS);
    assign wr_ct_s    = we & (a == PS2_CTRL);
    assign pop_s      = wr_rx_s & ~empty_s;
    assign flush_s    = wr_ct_s & d[CT_FLUSH];
    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    assign push_s     = rx_valid_s & (~full_s | pop_s) & ~flush_s;
    assign ovf_set_s  = rx_valid_s & full_s & ~pop_s & ~flush_s;
    assign head_s     = empty_s ? 8'h00 : mem_r[rd_ptr_r];

    // FIFO storage; contents need no reset since count gates visibility.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= rx_byte_s;
        end
    end

    // FIFO pointers, sticky status (set beats write-1-to-clear), control bits and irq.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
            count_r  <= {CW{1'b0}};
            perr_r   <= 1'b0;
            ferr_r   <= 1'b0;
            toerr_r  <= 1'b0;
            ovf_r    <= 1'b0;
            irq_en_r <= 1'b0;
            rx_en_r  <= 1'b1;
            irq_r    <= 1'b0;
        end else begin
            if (flush_s) begin
                wr_ptr_r <= {PW{1'b0}};
                rd_ptr_r <= {PW{1'b0}};
                count_r  <= {CW{1'b0}};
            end else begin
                if (push_s) wr_ptr_r <= wr_ptr_r + PW'(1);
                if (pop_s)  rd_ptr_r <= rd_ptr_r + PW'(1);
                count_r <= count_r + CW'(push_s) - CW'(pop_s);
            end
            perr_r  <= rx_perr_s  | (perr_r  & ~(wr_st_s & d[ST_PERR]));
            ferr_r  <= rx_ferr_s  | (ferr_r  & ~(wr_st_s & d[ST_FERR]));
            toerr_r <= rx_toerr_s | (toerr_r & ~(wr_st_s & d[ST_TOERR]));
            ovf_r   <= ovf_set_s  | (ovf_r   & ~(wr_st_s & d[ST_OVF]));
            if (wr_ct_s) begin
                irq_en_r <= d[CT_IRQ_EN];
                rx_en_r  <= d[CT_RX_EN];
            end
            if (IRQ_MODE == 0) begin
                irq_r <= irq_en_r & ~empty_s;
            end else begin
                irq_r <= irq_en_r & push_s;
            end
        end
    end

    // Combinational register read mux.
    always_comb begin
        spo = 32'h0000_0000;
        case (a)
            PS2_RXDATA: spo = {23'd0, ~empty_s, head_s};
            PS2_STATUS: spo = {16'd0, 8'(count_r), 2'b00, ovf_r, toerr_r, ferr_r, perr_r,
                               full_s, empty_s};
            PS2_CTRL:   spo = {30'd0, rx_en_r, irq_en_r};
            default:    spo = 32'h0000_0000;
        endcase
    end

    assign irq = irq_r;

endmodule

// File: tb/tb_ps2_kbd_ctrl.sv
// Scoreboard bench for ps2_kbd_ctrl: a pulse-irq instance carries the checks,
// a level-irq twin shares all stimulus for the level-mode irq checks.
module tb_ps2_kbd_ctrl;

    localparam int DEPTH  = 16;
    localparam int SYNC   = 2;
    localparam int FILT   = 8;
    localparam int TO_CYC = 300;
    localparam int HALF   = 20;

    logic        clk = 1'b0;
    logic        rst_n, we, kclk, kdata;
    logic [2:0]  a;
    logic [31:0] d, spo, spo_lvl, v;
    logic        irq, irq_lvl;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int pulse_cnt = 0;
    int last_fall_cyc = 0;
    int lat, k_wait;
    logic [7:0] exp_q[$];

    ps2_kbd_ctrl #(.FIFO_DEPTH(DEPTH), .SYNC_STAGES(SYNC), .FILTER_LEN(FILT),
                   .TIMEOUT_CYC(TO_CYC), .IRQ_MODE(1)) dut (
        .clk(clk), .rst_n(rst_n), .a(a), .d(d), .we(we), .spo(spo), .irq(irq),
        .kclk(kclk), .kdata(kdata));

    ps2_kbd_ctrl #(.FIFO_DEPTH(DEPTH), .SYNC_STAGES(SYNC), .FILTER_LEN(FILT),
                   .TIMEOUT_CYC(TO_CYC), .IRQ_MODE(0)) dut_lvl (
        .clk(clk), .rst_n(rst_n), .a(a), .d(d), .we(we), .spo(spo_lvl), .irq(irq_lvl),
        .kclk(kclk), .kdata(kdata));

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) if (irq === 1'b1) pulse_cnt++;

    initial begin
        #600000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic rd(input logic [2:0] addr, output logic [31:0] val);
        @(negedge clk);
        a = addr;
        #1 val = spo;
    endtask

    task automatic wr(input logic [2:0] addr, input logic [31:0] data);
        @(negedge clk);
        a = addr; d = data; we = 1'b1;
        @(negedge clk);
        we = 1'b0;
    endtask

    // Compare the head against the scoreboard, then pop it with an RXDATA write.
    task automatic pop_check(input string tag);
        logic [31:0] exp;
        @(negedge clk);
        a = 3'd0;
        #1;
        exp = (exp_q.size() > 0) ? {23'd0, 1'b1, exp_q[0]} : 32'h0;
        check(tag, spo, exp);
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        we = 1'b1;
        @(negedge clk);
        we = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                              input int nbits, input bit glitch);
        logic [10:0] fr;
        fr = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            kdata = fr[i];
            if (glitch && i == 4) begin
                repeat (8) @(negedge clk);
                kclk = 1'b0;
                repeat (3) @(negedge clk);
                kclk = 1'b1;
                repeat (HALF - 11) @(negedge clk);
            end else begin
                repeat (HALF) @(negedge clk);
            end
            kclk = 1'b0;
            last_fall_cyc = cyc;
            repeat (HALF) @(negedge clk);
            kclk = 1'b1;
        end
        kdata = 1'b1;
        repeat (20) @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0; kclk = 1'b1; kdata = 1'b1; a = 3'd0; d = 32'h0; we = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b1;

        rd(3'd1, v); check("reset_status", v, 32'h0000_0001);
        rd(3'd2, v); check("reset_ctrl", v, 32'h0000_0002);
        rd(3'd0, v); check("reset_rxdata", v, 32'h0000_0000);
        check("reset_irq", {31'd0, irq}, 32'd0);

        // Single frame with pulse irq and latency bound
        wr(3'd2, 32'h3);
        a = 3'd1;
        pulse_cnt = 0;
        fork
            send_frame(8'h1C, 1'b0, 1'b0, 11, 1'b0);
            begin
                for (k_wait = 0; k_wait < 3000; k_wait++) begin
                    @(negedge clk);
                    #1;
                    if (spo[0] == 1'b0) break;
                end
                lat = cyc - last_fall_cyc;
            end
        join
        exp_q.push_back(8'h1C);
        check("push_latency_ok", {31'd0, (k_wait < 3000) && (lat <= SYNC + FILT + 3)}, 32'd1);
        rd(3'd1, v); check("status_one", v, 32'h0000_0100);
        check("irq_lvl_set", {31'd0, irq_lvl}, 32'd1);
        check("irq_pulses_one", pulse_cnt, 32'd1);
        pop_check("rx_1c");

        // Two frames, two pops, level irq drop
        send_frame(8'hF0, 1'b0, 1'b0, 11, 1'b0); exp_q.push_back(8'hF0);
        send_frame(8'h1C, 1'b0, 1'b0, 11, 1'b0); exp_q.push_back(8'h1C);
        pop_check("rx_f0");
        pop_check("rx_1c_b");
        check("irq_lvl_hold", {31'd0, irq_lvl}, 32'd1);
        @(negedge clk);
        check("irq_lvl_drop", {31'd0, irq_lvl}, 32'd0);
        pop_check("rx_empty");
        rd(3'd1, v); check("status_empty", v, 32'h0000_0001);

        // Parity and framing errors
        send_frame(8'h1C, 1'b1, 1'b0, 11, 1'b0);
        rd(3'd1, v); check("status_perr", v, 32'h0000_0005);
        wr(3'd1, 32'h4);
        rd(3'd1, v); check("perr_clear", v, 32'h0000_0001);
        send_frame(8'h33, 1'b0, 1'b1, 11, 1'b0);
        rd(3'd1, v); check("status_ferr", v, 32'h0000_0009);
        wr(3'd1, 32'h8);

        // Timeout after four data bits, then recovery
        send_frame(8'hFF, 1'b0, 1'b0, 5, 1'b0);
        repeat (TO_CYC + 10) @(negedge clk);
        rd(3'd1, v); check("status_toerr", v, 32'h0000_0011);
        wr(3'd1, 32'h10);
        send_frame(8'h5A, 1'b0, 1'b0, 11, 1'b0); exp_q.push_back(8'h5A);
        pop_check("rx_5a");

        // Glitch on kclk mid-frame
        send_frame(8'hA5, 1'b0, 1'b0, 11, 1'b1); exp_q.push_back(8'hA5);
        pop_check("rx_a5_glitch");

        // Overflow: DEPTH+1 frames without popping
        pulse_cnt = 0;
        for (int i = 0; i <= DEPTH; i++) begin
            send_frame(8'(i + 1), 1'b0, 1'b0, 11, 1'b0);
            if (exp_q.size() < DEPTH) exp_q.push_back(8'(i + 1));
        end
        check("irq_pulses_ovf", pulse_cnt, DEPTH);
        rd(3'd1, v); check("status_ovf", v, 32'h0000_1022);
        rd(3'd0, v); check("head_intact", v, 32'h0000_0101);
        wr(3'd1, 32'h20);
        rd(3'd1, v); check("ovf_clear", v, 32'h0000_1002);

        // Pop coinciding with a push while full
        fork
            send_frame(8'h77, 1'b0, 1'b0, 11, 1'b0);
            begin
                for (k_wait = 0; k_wait < 3000; k_wait++) begin
                    @(negedge clk);
                    if (dut.u_rx.byte_valid === 1'b1) break;
                end
                check("coinc_seen", {31'd0, k_wait < 3000}, 32'd1);
                a = 3'd0;
                #1 check("coinc_head", spo, {23'd0, 1'b1, exp_q[0]});
                void'(exp_q.pop_front());
                we = 1'b1;
                @(negedge clk);
                we = 1'b0;
            end
        join
        exp_q.push_back(8'h77);
        rd(3'd1, v); check("status_coinc", v, 32'h0000_1002);
        for (int i = 0; i < DEPTH; i++) pop_check("drain");
        rd(3'd1, v); check("status_drained", v, 32'h0000_0001);

        // Flush
        send_frame(8'h11, 1'b0, 1'b0, 11, 1'b0);
        wr(3'd2, 32'h7);
        rd(3'd1, v); check("status_flush", v, 32'h0000_0001);

        // Reset mid-frame
        send_frame(8'h42, 1'b0, 1'b0, 11, 1'b0);
        send_frame(8'hC3, 1'b0, 1'b0, 5, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        exp_q.delete();
        rd(3'd1, v); check("rst_status", v, 32'h0000_0001);
        rd(3'd2, v); check("rst_ctrl", v, 32'h0000_0002);
        check("rst_irq", {30'd0, irq, irq_lvl}, 32'd0);
        repeat (TO_CYC) @(negedge clk);
        rd(3'd1, v); check("rst_no_partial", v, 32'h0000_0001);
        send_frame(8'h3C, 1'b0, 1'b0, 11, 1'b0); exp_q.push_back(8'h3C);
        pop_check("rx_3c_after_rst");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
